// File: rtl/wallace_seq8.sv
// 8x8 unsigned sequential multiplier built around a single 4x4 Wallace-tree core.
// Four partial products are accumulated over four MUL cycles.

module wallace_mul4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);

  logic [7:0] r0, r1, r2, r3;
  logic [7:0] s1, c1, s2, c2;

  // Two carry-save layers reduce four rows to two, then a single carry-propagate add.
  always_comb begin
    r0 = {4'b0000, a_i & {4{b_i[0]}}};
    r1 = {3'b000, a_i & {4{b_i[1]}}, 1'b0};
    r2 = {2'b00, a_i & {4{b_i[2]}}, 2'b00};
    r3 = {1'b0, a_i & {4{b_i[3]}}, 3'b000};
    s1 = r0 ^ r1 ^ r2;
    c1 = ((r0 & r1) | (r0 & r2) | (r1 & r2)) << 1;
    s2 = s1 ^ c1 ^ r3;
    c2 = ((s1 & c1) | (s1 & r3) | (c1 & r3)) << 1;
    p_o = s2 + c2;
  end

endmodule

module wallace_seq8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        abort,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] prod,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [7:0]  opa_q, opa_d;
  logic [7:0]  opb_q, opb_d;
  logic [15:0] acc_q, acc_d;

  logic [3:0]  mul_a, mul_b;
  logic [7:0]  pp;
  logic [15:0] pp_shifted;

  wallace_mul4 u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (pp)
  );

  // step[0] selects the high nibble of a, step[1] the high nibble of b.
  always_comb begin
    mul_a = step_q[0] ? opa_q[7:4] : opa_q[3:0];
    mul_b = step_q[1] ? opb_q[7:4] : opb_q[3:0];
    unique case (step_q)
      2'd0:    pp_shifted = {8'h00, pp};
      2'd1,
      2'd2:    pp_shifted = {4'h0, pp, 4'h0};
      default: pp_shifted = {pp, 8'h00};
    endcase
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    if (abort) begin
      state_d = StIdle;
      step_d  = 2'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            opa_d   = a;
            opb_d   = b;
            acc_d   = 16'h0000;
            step_d  = 2'd0;
            state_d = StMul;
          end
        end
        StMul: begin
          acc_d  = acc_q + pp_shifted;
          step_d = step_q + 2'd1;
          if (step_q == 2'd3) state_d = StDone;
        end
        StDone: begin
          if (out_ready) state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
          step_d  = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      step_q  <= 2'd0;
      opa_q   <= 8'h00;
      opb_q   <= 8'h00;
      acc_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign prod      = acc_q;

endmodule

// File: tb/tb_wallace_seq8.sv
// Directed and randomised checks of wallace_seq8 against a plain a*b reference
// with an in-order queue of expected products.

module tb_wallace_seq8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] prod;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  localparam int NumOps   = 1500;
  localparam int MaxCyc   = 40000;

  wallace_seq8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, {15'b0, in_ready}, 16'h0001);
    check({tag, "_out_valid"}, {15'b0, out_valid}, 16'h0000);
    check({tag, "_busy"}, {15'b0, busy}, 16'h0000);
  endtask

  // Present one operand pair for a single edge.
  task automatic accept(input logic [7:0] av, input logic [7:0] bv);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 20) begin
      tick();
      edges++;
    end
  endtask

  initial begin
    int edges;
    int accepted;
    int retired;
    int cyc;
    logic [15:0] expq[$];
    logic [7:0] ca[8];
    logic [7:0] cb[8];

    ca = '{8'h00, 8'hFF, 8'hFF, 8'h01, 8'h80, 8'h0F, 8'hF0, 8'hAA};
    cb = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h80, 8'hF0, 8'h0F, 8'h55};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    abort     = 1'b0;
    out_ready = 1'b0;
    #3;
    check_idle("reset");
    check("reset_prod", prod, 16'h0000);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_idle("post_reset");

    // FF*FF with out_ready high: one-cycle result after 5 edges.
    out_ready = 1'b1;
    accept(8'hFF, 8'hFF);
    check("ff_busy", {15'b0, busy}, 16'h0001);
    check("ff_in_ready", {15'b0, in_ready}, 16'h0000);
    wait_valid(edges);
    check("ff_latency", 16'(edges), 16'd4);
    check("ff_prod", prod, 16'hFE01);
    tick();
    check("ff_single_cycle", {15'b0, out_valid}, 16'h0000);
    check("ff_in_ready_after", {15'b0, in_ready}, 16'h0001);

    // 12*34 held under backpressure.
    out_ready = 1'b0;
    accept(8'h12, 8'h34);
    wait_valid(edges);
    check("hold_latency", 16'(edges), 16'd4);
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", {15'b0, out_valid}, 16'h0001);
      check("hold_prod", prod, 16'h03A8);
      tick();
    end
    check("hold_still_valid", {15'b0, out_valid}, 16'h0001);
    out_ready = 1'b1;
    tick();
    check("hold_released", {15'b0, out_valid}, 16'h0000);

    // Operands must be captured at acceptance.
    accept(8'h80, 8'h02);
    for (int i = 0; i < 4; i++) begin
      a        = 8'hFF;
      b        = 8'hFF;
      in_valid = 1'(i & 1);
      tick();
    end
    in_valid = 1'b0;
    check("capture_valid", {15'b0, out_valid}, 16'h0001);
    check("capture_prod", prod, 16'h0100);
    tick();

    // Abort on the step-2 edge.
    accept(8'h0F, 8'hF0);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort");
    for (int i = 0; i < 6; i++) begin
      check("abort_no_result", {15'b0, out_valid}, 16'h0000);
      tick();
    end
    accept(8'h03, 8'h05);
    wait_valid(edges);
    check("after_abort_latency", 16'(edges), 16'd4);
    check("after_abort_prod", prod, 16'h000F);
    tick();

    // Abort beats acceptance.
    in_valid = 1'b1;
    abort    = 1'b1;
    tick();
    in_valid = 1'b0;
    abort    = 1'b0;
    check_idle("abort_vs_accept");

    // Abort beats the out_ready handshake in DONE as well.
    out_ready = 1'b0;
    accept(8'h07, 8'h09);
    wait_valid(edges);
    check("abort_done_prod", prod, 16'h003F);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort_done");
    out_ready = 1'b1;

    // Asynchronous reset during MUL step 1.
    accept(8'h5A, 8'hC3);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("mid_reset");
    check("mid_reset_prod", prod, 16'h0000);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("mid_reset_no_result", {15'b0, out_valid}, 16'h0000);
      tick();
    end

    // Randomised traffic with backpressure against an in-order queue of a*b.
    accepted = 0;
    retired  = 0;
    cyc      = 0;
    while ((accepted < NumOps || expq.size() != 0) && cyc < MaxCyc) begin
      in_valid  = (accepted < NumOps) && ($urandom_range(3) != 0);
      if (accepted < 8) begin
        a = ca[accepted];
        b = cb[accepted];
      end else begin
        a = 8'($urandom);
        b = 8'($urandom);
      end
      out_ready = 1'($urandom_range(1));
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("rnd_spurious", {15'b0, out_valid}, 16'h0000);
        end else begin
          check("rnd_prod", prod, expq[0]);
          if (out_ready) begin
            void'(expq.pop_front());
            retired++;
          end
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back(16'(a) * 16'(b));
        accepted++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("rnd_timeout", {15'b0, 1'(cyc < MaxCyc)}, 16'h0001);
    check("rnd_drained", 16'(expq.size()), 16'h0000);
    check("rnd_retired", 16'(retired), 16'(NumOps));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
